// File: rtl/lane_commit_buffer.sv
// In-order commit FIFO between the lane's functional-unit selector and the VRF write port.
// Drains through a valid/ready handshake, supports flush, and counts completed VRF writes.
module lane_commit_buffer #(
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned ADDR_WIDTH  = 5,
    parameter int unsigned DATA_WIDTH  = 64,
    parameter int unsigned COUNT_WIDTH = 16,
    localparam int unsigned PTR_WIDTH  = $clog2(DEPTH),
    localparam int unsigned OCC_WIDTH  = PTR_WIDTH + 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [ADDR_WIDTH-1:0]  vector_destination_address,
    input  logic [DATA_WIDTH-1:0]  vd,
    input  logic                   flush,
    output logic                   vrf_we,
    input  logic                   vrf_ready,
    output logic [ADDR_WIDTH-1:0]  vrf_waddr,
    output logic [DATA_WIDTH-1:0]  vrf_wdata,
    output logic [OCC_WIDTH-1:0]   occupancy,
    output logic [COUNT_WIDTH-1:0] commit_count
);

    localparam logic [OCC_WIDTH-1:0] OccFull = OCC_WIDTH'(DEPTH);

    logic [PTR_WIDTH-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_WIDTH-1:0]   rd_ptr_q, rd_ptr_d;
    logic [OCC_WIDTH-1:0]   occ_q, occ_d;
    logic [COUNT_WIDTH-1:0] count_q, count_d;

    logic [ADDR_WIDTH-1:0] addr_mem [DEPTH];
    logic [DATA_WIDTH-1:0] data_mem [DEPTH];

    logic full, empty, push, pop;

    assign full  = (occ_q == OccFull);
    assign empty = (occ_q == '0);

    // Ready depends only on held state and flush, never on vrf_ready.
    assign in_ready = ~full & ~flush;
    // No VRF write may be issued in a cycle where reset is being applied.
    assign vrf_we   = ~empty & ~flush & rst_n;

    assign push = in_valid & in_ready;
    assign pop  = vrf_we & vrf_ready;

    assign vrf_waddr    = vrf_we ? addr_mem[rd_ptr_q] : '0;
    assign vrf_wdata    = vrf_we ? data_mem[rd_ptr_q] : '0;
    assign occupancy    = occ_q;
    assign commit_count = count_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        count_d  = count_q + COUNT_WIDTH'(pop);
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            occ_d    = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_WIDTH'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_WIDTH'(1);
            end
            case ({push, pop})
                2'b10:   occ_d = occ_q + OCC_WIDTH'(1);
                2'b01:   occ_d = occ_q - OCC_WIDTH'(1);
                default: occ_d = occ_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset; outputs are masked while vrf_we is low.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[wr_ptr_q] <= vector_destination_address;
            data_mem[wr_ptr_q] <= vd;
        end
    end

endmodule

// File: tb/tb_lane_commit_buffer.sv
// Bench for lane_commit_buffer: directed vector table, hand-written corner sequences and
// random traffic checked against a queue-based reference model.
module tb_lane_commit_buffer;

    localparam int unsigned DEPTH = 4;

    typedef struct {
        logic        iv;
        logic [4:0]  a;
        logic [63:0] d;
        logic        fl;
        logic        rdy;
        logic [2:0]  occ;
        logic        ir;
        logic        we;
        logic [4:0]  wa;
        logic [63:0] wd;
        logic [15:0] cnt;
    } vec_t;

    typedef struct {
        logic [4:0]  a;
        logic [63:0] d;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst_n, in_valid, flush, vrf_ready;
    logic [4:0]  addr;
    logic [63:0] vd;
    logic        in_ready, vrf_we;
    logic [4:0]  vrf_waddr;
    logic [63:0] vrf_wdata;
    logic [2:0]  occupancy;
    logic [15:0] commit_count;
    logic        in_ready_w, vrf_we_w;
    logic [4:0]  vrf_waddr_w;
    logic [63:0] vrf_wdata_w;
    logic [2:0]  occupancy_w;
    logic [3:0]  commit_count_w;

    int n_checks = 0;
    int n_err    = 0;

    ent_t        mq[$];
    logic [31:0] m_cnt = 0;

    always #5 clk = ~clk;

    lane_commit_buffer #(.DEPTH(DEPTH), .ADDR_WIDTH(5), .DATA_WIDTH(64), .COUNT_WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .vector_destination_address(addr), .vd(vd), .flush(flush),
        .vrf_we(vrf_we), .vrf_ready(vrf_ready), .vrf_waddr(vrf_waddr), .vrf_wdata(vrf_wdata),
        .occupancy(occupancy), .commit_count(commit_count)
    );

    lane_commit_buffer #(.DEPTH(DEPTH), .ADDR_WIDTH(5), .DATA_WIDTH(64), .COUNT_WIDTH(4)) dut_w (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_w),
        .vector_destination_address(addr), .vd(vd), .flush(flush),
        .vrf_we(vrf_we_w), .vrf_ready(vrf_ready), .vrf_waddr(vrf_waddr_w),
        .vrf_wdata(vrf_wdata_w), .occupancy(occupancy_w), .commit_count(commit_count_w)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic iv, input logic [4:0] a, input logic [63:0] d,
                                input logic fl, input logic rdy, input logic [2:0] occ,
                                input logic ir, input logic we, input logic [4:0] wa,
                                input logic [63:0] wd, input logic [15:0] cnt);
        vec_t v;
        v.iv = iv; v.a = a; v.d = d; v.fl = fl; v.rdy = rdy; v.occ = occ;
        v.ir = ir; v.we = we; v.wa = wa; v.wd = wd; v.cnt = cnt;
        return v;
    endfunction

    // One clock: drive inputs, compare mid-cycle, then advance the model across the edge.
    task automatic step(input logic iv, input logic [4:0] a, input logic [63:0] d,
                        input logic fl, input logic rdy, input logic rn,
                        input bit use_tbl, input vec_t v, input string tag);
        logic        e_we, e_ir;
        logic [4:0]  e_wa;
        logic [63:0] e_wd;
        rst_n = rn; in_valid = iv; addr = a; vd = d; flush = fl; vrf_ready = rdy;
        e_we = rn && (mq.size() != 0) && !fl;
        e_ir = (mq.size() != DEPTH) && !fl;
        e_wa = e_we ? mq[0].a : 5'd0;
        e_wd = e_we ? mq[0].d : 64'd0;
        @(negedge clk);
        if (use_tbl) begin
            check({tag, " occupancy"}, 64'(occupancy), 64'(v.occ));
            check({tag, " in_ready"}, 64'(in_ready), 64'(v.ir));
            check({tag, " vrf_we"}, 64'(vrf_we), 64'(v.we));
            check({tag, " vrf_waddr"}, 64'(vrf_waddr), 64'(v.wa));
            check({tag, " vrf_wdata"}, vrf_wdata, v.wd);
            check({tag, " commit_count"}, 64'(commit_count), 64'(v.cnt));
        end else begin
            check({tag, " occupancy"}, 64'(occupancy), 64'(mq.size()));
            check({tag, " in_ready"}, 64'(in_ready), 64'(e_ir));
            check({tag, " vrf_we"}, 64'(vrf_we), 64'(e_we));
            check({tag, " vrf_waddr"}, 64'(vrf_waddr), 64'(e_wa));
            check({tag, " vrf_wdata"}, vrf_wdata, e_wd);
            check({tag, " commit_count"}, 64'(commit_count), 64'(m_cnt[15:0]));
            check({tag, " narrow occupancy"}, 64'(occupancy_w), 64'(mq.size()));
            check({tag, " narrow vrf_we"}, 64'(vrf_we_w), 64'(e_we));
            check({tag, " narrow in_ready"}, 64'(in_ready_w), 64'(e_ir));
            check({tag, " narrow vrf_waddr"}, 64'(vrf_waddr_w), 64'(e_wa));
            check({tag, " narrow vrf_wdata"}, vrf_wdata_w, e_wd);
            check({tag, " narrow commit_count"}, 64'(commit_count_w), 64'(m_cnt[3:0]));
        end
        if (!rn) begin
            mq.delete();
            m_cnt = 0;
        end else if (fl) begin
            mq.delete();
        end else begin
            if (e_we && rdy) begin
                void'(mq.pop_front());
                m_cnt++;
            end
            if (iv && e_ir) mq.push_back('{a: a, d: d});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic mstep(input logic iv, input logic [4:0] a, input logic [63:0] d,
                         input logic fl, input logic rdy, input logic rn, input string tag);
        vec_t dummy;
        dummy = mk(1'b0, 5'd0, 64'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 5'd0, 64'd0, 16'd0);
        step(iv, a, d, fl, rdy, rn, 1'b0, dummy, tag);
    endtask

    vec_t        tbl[17];
    logic [31:0] saved;

    initial begin
        tbl[0]  = mk(0, 5'd0, 64'h0, 0, 0, 3'd0, 1, 0, 5'd0, 64'h0, 16'd0);
        tbl[1]  = mk(1, 5'd3, 64'hDEAD_BEEF, 0, 1, 3'd0, 1, 0, 5'd0, 64'h0, 16'd0);
        tbl[2]  = mk(0, 5'd0, 64'h0, 0, 1, 3'd1, 1, 1, 5'd3, 64'hDEAD_BEEF, 16'd0);
        tbl[3]  = mk(0, 5'd0, 64'h0, 0, 1, 3'd0, 1, 0, 5'd0, 64'h0, 16'd1);
        tbl[4]  = mk(1, 5'd1, 64'h11, 0, 0, 3'd0, 1, 0, 5'd0, 64'h0, 16'd1);
        tbl[5]  = mk(1, 5'd2, 64'h22, 0, 0, 3'd1, 1, 1, 5'd1, 64'h11, 16'd1);
        tbl[6]  = mk(1, 5'd3, 64'h33, 0, 0, 3'd2, 1, 1, 5'd1, 64'h11, 16'd1);
        tbl[7]  = mk(1, 5'd4, 64'h44, 0, 0, 3'd3, 1, 1, 5'd1, 64'h11, 16'd1);
        tbl[8]  = mk(1, 5'd5, 64'h55, 0, 0, 3'd4, 0, 1, 5'd1, 64'h11, 16'd1);
        tbl[9]  = mk(1, 5'd5, 64'h55, 0, 1, 3'd4, 0, 1, 5'd1, 64'h11, 16'd1);
        tbl[10] = mk(1, 5'd6, 64'h66, 0, 1, 3'd3, 1, 1, 5'd2, 64'h22, 16'd2);
        tbl[11] = mk(0, 5'd0, 64'h0, 0, 1, 3'd3, 1, 1, 5'd3, 64'h33, 16'd3);
        tbl[12] = mk(1, 5'd9, 64'h99, 1, 1, 3'd2, 0, 0, 5'd0, 64'h0, 16'd4);
        tbl[13] = mk(0, 5'd0, 64'h0, 0, 1, 3'd0, 1, 0, 5'd0, 64'h0, 16'd4);
        tbl[14] = mk(1, 5'd7, 64'h77, 0, 1, 3'd0, 1, 0, 5'd0, 64'h0, 16'd4);
        tbl[15] = mk(0, 5'd0, 64'h0, 0, 1, 3'd1, 1, 1, 5'd7, 64'h77, 16'd4);
        tbl[16] = mk(0, 5'd0, 64'h0, 0, 0, 3'd0, 1, 0, 5'd0, 64'h0, 16'd5);

        rst_n = 1'b0; in_valid = 1'b0; addr = '0; vd = '0; flush = 1'b0; vrf_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        for (int i = 0; i < 17; i++) begin
            step(tbl[i].iv, tbl[i].a, tbl[i].d, tbl[i].fl, tbl[i].rdy, 1'b1, 1'b1, tbl[i],
                 $sformatf("vec%0d", i));
        end

        // Streaming: push and pop every cycle.
        saved = m_cnt;
        for (int i = 0; i < 20; i++) begin
            mstep(1'b1, 5'(i), {32'(i), $urandom}, 1'b0, 1'b1, 1'b1, $sformatf("stream%0d", i));
        end
        mstep(1'b0, 5'd0, 64'd0, 1'b0, 1'b1, 1'b1, "stream drain");
        mstep(1'b0, 5'd0, 64'd0, 1'b0, 1'b1, 1'b1, "stream idle");
        check("stream commit total", 64'(commit_count), 64'(saved + 20));

        // Flush with three entries queued.
        for (int i = 0; i < 3; i++) begin
            mstep(1'b1, 5'(10 + i), 64'(i), 1'b0, 1'b0, 1'b1, $sformatf("preflush%0d", i));
        end
        saved = m_cnt;
        mstep(1'b1, 5'd20, 64'hAA, 1'b1, 1'b1, 1'b1, "flush");
        check("flush occupancy", 64'(occupancy), 64'd0);
        check("flush keeps count", 64'(commit_count), 64'(saved));
        mstep(1'b1, 5'd7, 64'h7777, 1'b0, 1'b1, 1'b1, "postflush push");
        mstep(1'b0, 5'd0, 64'd0, 1'b0, 1'b1, 1'b1, "postflush write");
        mstep(1'b0, 5'd0, 64'd0, 1'b0, 1'b1, 1'b1, "postflush idle");

        // Counter wrap on the narrow instance.
        mstep(1'b0, 5'd0, 64'd0, 1'b0, 1'b0, 1'b0, "wrap reset");
        for (int i = 0; i < 17; i++) begin
            mstep(1'b1, 5'(i), 64'(i), 1'b0, 1'b1, 1'b1, $sformatf("wrap push%0d", i));
            mstep(1'b0, 5'd0, 64'd0, 1'b0, 1'b1, 1'b1, $sformatf("wrap pop%0d", i));
        end
        check("wrap narrow count", 64'(commit_count_w), 64'd1);
        check("wrap wide count", 64'(commit_count), 64'd17);

        // Reset mid-stream with two entries queued and the VRF ready.
        mstep(1'b1, 5'd1, 64'h1, 1'b0, 1'b0, 1'b1, "midrst push0");
        mstep(1'b1, 5'd2, 64'h2, 1'b0, 1'b0, 1'b1, "midrst push1");
        mstep(1'b0, 5'd0, 64'd0, 1'b0, 1'b1, 1'b0, "midrst reset");
        for (int i = 0; i < 3; i++) begin
            mstep(1'b0, 5'd0, 64'd0, 1'b0, 1'b1, 1'b1, $sformatf("midrst idle%0d", i));
        end

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            mstep($urandom_range(0, 99) < 70, 5'($urandom), {$urandom, $urandom},
                  $urandom_range(0, 99) < 4, $urandom_range(0, 99) < 60,
                  !($urandom_range(0, 99) < 2), $sformatf("rand%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
